// File: rtl/mips_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the combinational instruction
// memory and holds one fetched word for decode behind a valid/ready handshake.
module mips_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        out_valid_n;
  logic [31:0] out_inst_n, out_pc_n, fault_pc_n;
  logic        transfer, slot_free;

  function automatic logic is_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST_PC);
  endfunction

  assign transfer  = out_valid && out_ready;
  assign slot_free = !out_valid || out_ready;
  assign imem_addr = pc;
  assign halted    = (state == HALT);
  assign fault     = (state == FAULT);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    out_inst_n  = out_inst;
    out_pc_n    = out_pc;
    fault_pc_n  = fault_pc;
    // A pending entry drains on handshake in every state unless overridden below.
    out_valid_n = out_valid && !out_ready;

    unique case (state)
      IDLE: begin
        state_n     = RUN;
        out_valid_n = 1'b0;
      end
      RUN: begin
        if (redirect_valid) begin
          out_valid_n = 1'b0;
          if (is_legal(redirect_pc)) begin
            pc_n = redirect_pc;
          end else begin
            state_n    = FAULT;
            fault_pc_n = redirect_pc;
          end
        end else if (halt_req) begin
          state_n = HALT;
        end else if (slot_free) begin
          if (is_legal(pc)) begin
            out_inst_n  = imem_data;
            out_pc_n    = pc;
            out_valid_n = 1'b1;
            pc_n        = pc + 32'd4;
          end else begin
            state_n     = FAULT;
            fault_pc_n  = pc;
            out_valid_n = 1'b0;
          end
        end
      end
      HALT: begin
        if (redirect_valid) begin
          out_valid_n = 1'b0;
          if (is_legal(redirect_pc)) begin
            state_n = RUN;
            pc_n    = redirect_pc;
          end else begin
            state_n    = FAULT;
            fault_pc_n = redirect_pc;
          end
        end else if (!halt_req) begin
          state_n = RUN;
        end
      end
      FAULT: begin
        out_valid_n = 1'b0;
      end
      default: begin
        state_n     = IDLE;
        out_valid_n = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_inst    <= 32'd0;
      out_pc      <= 32'd0;
      fault_pc    <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      out_valid <= out_valid_n;
      out_inst  <= out_inst_n;
      out_pc    <= out_pc_n;
      fault_pc  <= fault_pc_n;
      if (transfer) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_mips_fetch_ctrl.sv
// Directed bench for mips_fetch_ctrl: a small word memory model supplies imem_data and
// each step checks outputs 1 ns after the rising edge.
module tb_mips_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid, out_ready;
  logic [31:0] out_inst, out_pc;
  logic        halted, fault;
  logic [31:0] fault_pc, fetch_count;

  int tests  = 0;
  int failed = 0;

  logic [31:0] mem [256];

  mips_fetch_ctrl #(.RESET_PC(32'h0), .MEM_BYTES(1024)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .halted         (halted),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    imem_data = 32'hDEAD_BEEF;
    if (imem_addr < 32'd1024) imem_data = mem[imem_addr[9:2]];
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem[a[9:2]];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " out_valid"},   32'(out_valid), 32'd0);
    check({tag, " out_inst"},    out_inst,       32'd0);
    check({tag, " out_pc"},      out_pc,         32'd0);
    check({tag, " halted"},      32'(halted),    32'd0);
    check({tag, " fault"},       32'(fault),     32'd0);
    check({tag, " fault_pc"},    fault_pc,       32'd0);
    check({tag, " fetch_count"}, fetch_count,    32'd0);
    check({tag, " imem_addr"},   imem_addr,      32'd0);
  endtask

  // Reset, then run until the first instruction (pc 0) is presented.
  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0; out_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 | (i << 2);
    mem[32'h00 >> 2] = 32'h0000_8020;
    mem[32'h04 >> 2] = 32'h2011_000A;
    mem[32'h08 >> 2] = 32'h2012_0014;
    mem[32'h18 >> 2] = 32'hAD09_0000;
    mem[32'h24 >> 2] = 32'h0800_0006;
    mem[32'h40 >> 2] = 32'h0800_000D;

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; halt_req = 1'b0; out_ready = 1'b1;

    // 1. reset then free-run
    step();
    check_reset_state("t1_reset");
    rst = 1'b0;
    step();
    check("t1 idle out_valid", 32'(out_valid), 32'd0);
    step();
    check("t1 first out_valid", 32'(out_valid), 32'd1);
    check("t1 first out_pc",    out_pc,   32'h0);
    check("t1 first out_inst",  out_inst, 32'h0000_8020);
    step();
    check("t1 out_pc 4",   out_pc,   32'h4);
    check("t1 out_inst 4", out_inst, 32'h2011_000A);
    step();
    check("t1 out_pc 8",   out_pc,   32'h8);
    check("t1 out_inst 8", out_inst, 32'h2012_0014);
    step();
    check("t1 fetch_count", fetch_count, 32'd3);

    // 2. backpressure on out_pc=4
    do_reset();
    step();
    check("t2 out_pc 4", out_pc, 32'h4);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2 hold out_inst",  out_inst,  32'h2011_000A);
      check("t2 hold out_pc",    out_pc,    32'h4);
      check("t2 hold imem_addr", imem_addr, 32'h8);
    end
    out_ready = 1'b1;
    step();
    check("t2 release out_pc",  out_pc,      32'h8);
    check("t2 release count",   fetch_count, 32'd2);
    step();
    check("t2 next out_pc",     out_pc,      32'hC);

    // 3. redirect with flush (stream continues from t2: out_pc=0xC, count=3)
    for (int i = 0; i < 6; i++) step();
    check("t3 out_pc 24",   out_pc,      32'h24);
    check("t3 out_inst 24", out_inst,    32'h0800_0006);
    check("t3 count",       fetch_count, 32'd9);
    redirect_valid = 1'b1; redirect_pc = 32'h18; out_ready = 1'b0;
    step();
    check("t3 flush out_valid", 32'(out_valid), 32'd0);
    check("t3 flush count",     fetch_count,    32'd9);
    check("t3 flush imem_addr", imem_addr,      32'h18);
    redirect_valid = 1'b0; out_ready = 1'b1;
    step();
    check("t3 target out_pc",   out_pc,   32'h18);
    check("t3 target out_inst", out_inst, 32'hAD09_0000);
    redirect_valid = 1'b1; redirect_pc = 32'h30; halt_req = 1'b1;
    step();
    check("t3 redir+halt halted",    32'(halted), 32'd0);
    check("t3 redir+halt imem_addr", imem_addr,   32'h30);
    check("t3 redir+halt count",     fetch_count, 32'd10);
    redirect_valid = 1'b0; halt_req = 1'b0;
    step();
    check("t3 redir+halt out_pc", out_pc,              32'h30);
    check("t3 redir+halt valid",  32'(out_valid),      32'd1);
    check("t3 redir+halt inst",   out_inst, word_at(32'h30));

    // 4. halt / resume
    do_reset();
    step(); step(); step();
    check("t4 out_pc C", out_pc, 32'hC);
    halt_req = 1'b1; out_ready = 1'b0;
    step();
    check("t4 halted",        32'(halted),    32'd1);
    check("t4 pending valid", 32'(out_valid), 32'd1);
    check("t4 pending pc",    out_pc,         32'hC);
    check("t4 imem_addr",     imem_addr,      32'h10);
    out_ready = 1'b1;
    step();
    check("t4 drain valid", 32'(out_valid), 32'd0);
    check("t4 drain count", fetch_count,    32'd4);
    step();
    check("t4 no capture",  32'(out_valid), 32'd0);
    check("t4 still halted", 32'(halted),   32'd1);
    halt_req = 1'b0;
    step();
    check("t4 resume halted", 32'(halted), 32'd0);
    step();
    check("t4 resume out_pc", out_pc, 32'h10);
    halt_req = 1'b1;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    check("t4 redirect halted", 32'(halted), 32'd0);
    redirect_valid = 1'b0; halt_req = 1'b0;
    step();
    check("t4 redirect out_pc",   out_pc,   32'h40);
    check("t4 redirect out_inst", out_inst, 32'h0800_000D);

    // 5a. misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h1A;
    step();
    check("t5 mis fault",     32'(fault),     32'd1);
    check("t5 mis fault_pc",  fault_pc,       32'h1A);
    check("t5 mis out_valid", 32'(out_valid), 32'd0);
    redirect_pc = 32'h8; halt_req = 1'b1;
    step();
    check("t5 ignore fault",     32'(fault),  32'd1);
    check("t5 ignore halted",    32'(halted), 32'd0);
    check("t5 ignore imem_addr", imem_addr,   32'h44);
    check("t5 ignore fault_pc",  fault_pc,    32'h1A);
    rst = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0;
    step();
    check_reset_state("t5_reset");

    // 5b. sequential fetch runs off the end of memory
    do_reset();
    for (int i = 0; i < 255; i++) step();
    check("t5 last out_pc",    out_pc,         32'h3FC);
    check("t5 last out_inst",  out_inst,       word_at(32'h3FC));
    check("t5 last valid",     32'(out_valid), 32'd1);
    check("t5 last imem_addr", imem_addr,      32'h400);
    step();
    check("t5 oob fault",     32'(fault),     32'd1);
    check("t5 oob fault_pc",  fault_pc,       32'h400);
    check("t5 oob out_valid", 32'(out_valid), 32'd0);
    check("t5 oob count",     fetch_count,    32'd256);

    // 6. reset mid-handshake
    do_reset();
    step();
    out_ready = 1'b0;
    step();
    check("t6 pending valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    check_reset_state("t6_reset");
    rst = 1'b0; out_ready = 1'b1;
    step();
    step();
    check("t6 first out_pc",   out_pc,   32'h0);
    check("t6 first out_inst", out_inst, 32'h0000_8020);
    step();
    check("t6 second out_pc",  out_pc,   32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mips_fetch_ctrl.md
Name: mips_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the MIPS core.
- Owns the program counter, drives the byte address of the combinational instruction memory, and captures the returned word into a one-entry fetch output register with a valid/ready handshake to decode.
- Handles branch/jump redirects, halt requests and out-of-range or misaligned fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_BYTES, 1024, instruction memory size in bytes; legal fetch PCs are 0 to MEM_BYTES-4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- imem_addr  output  32  byte address to instruction memory; always equals the internal pc.
- imem_data  input  32  big-endian word from instruction memory, valid combinationally in the same cycle.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  32  target byte address.
- halt_req  input  1  stop issuing new fetches.
- out_valid  output  1  out_inst/out_pc hold a fetched instruction.
- out_ready  input  1  decode accepts the instruction this cycle.
- out_inst  output  32  fetched instruction.
- out_pc  output  32  address of out_inst.
- halted  output  1  block is in HALT state.
- fault  output  1  sticky fetch fault.
- fault_pc  output  32  offending address.
- fetch_count  output  32  number of completed out handshakes.

Behaviour:
- **Reset** (rst=1 at an edge):
  - pc=RESET_PC, state=IDLE.
  - out_valid=0, out_inst=0, out_pc=0.
  - halted=0, fault=0, fault_pc=0, fetch_count=0.
  - Reset overrides every other input, including mid-handshake and in FAULT.
- **Legal PC:** pc[1:0]==0 and pc <= MEM_BYTES-4 (unsigned).
- **States:** IDLE, RUN, HALT, FAULT.
- **IDLE:** unconditionally goes to RUN next cycle. No fetch is issued; inputs are ignored.
- **slot_free** = !out_valid || out_ready.
- **RUN, evaluated in priority order:**
  1. **redirect_valid:**
     - Legal redirect_pc: pc<=redirect_pc; out_valid<=0 (flush, even if out_ready=0); no capture this cycle.
     - Illegal redirect_pc: go to FAULT; fault_pc<=redirect_pc; out_valid<=0.
  2. **halt_req:** go to HALT; no capture; pc unchanged. The pending out entry remains and may still handshake.
  3. **slot_free with legal pc:** out_inst<=imem_data; out_pc<=pc; out_valid<=1; pc<=pc+4 (32-bit wrap).
  4. **slot_free with illegal pc:** go to FAULT; fault_pc<=pc; out_valid<=0.
  5. **Otherwise (stall):** pc and out_* hold.
- **Fetch latency:** one cycle from pc presentation to out_valid. With out_ready held high, one instruction is delivered per cycle.
- **Handshake:**
  - Transfer occurs when out_valid && out_ready.
  - out_inst/out_pc must be stable while out_valid && !out_ready.
- **HALT:**
  - halted=1 in this state.
  - halt_req is a level: while it is high, the block stays in HALT.
  - Pending out entry drains normally: out_valid clears on handshake; no new capture.
  - Legal redirect_valid → RUN with pc<=redirect_pc and out_valid<=0 (regardless of halt_req).
  - Illegal redirect → FAULT.
  - halt_req low with no redirect → RUN, resuming at the held pc.
- **FAULT:**
  - fault=1; out_valid=0; pc held.
  - All inputs are ignored until rst.
- **fetch_count:**
  - Increments by 1 on every transfer, in any state.
  - Wraps at 2^32.
  - A redirect flush in the same cycle as out_valid && out_ready still counts the transfer.

Test Plan:
1. **Reset then free-run** (out_ready=1, memory holds words 0x00008020 @0, 0x2011000A @4, 0x20120014 @8):
   - out_valid first rises 2 cycles after rst falls, with out_pc=0, out_inst=0x00008020.
   - Next cycles deliver out_pc=4 (0x2011000A), then out_pc=8 (0x20120014).
   - fetch_count=3 after three transfers.
2. **Backpressure:** hold out_ready=0 for 4 cycles while out_pc=4 is valid.
   - out_inst stays 0x2011000A; imem_addr stays 8.
   - On release, out_pc=8 follows the next cycle; no instruction is skipped or duplicated.
3. **Redirect with flush:** while out_valid=1 and out_pc=0x24 (0x08000006), assert redirect_valid with redirect_pc=0x18 and out_ready=0.
   - Next cycle: out_valid=0, fetch_count unchanged.
   - Following cycle: out_pc=0x18, out_inst=0xAD090000.
   - Redirect plus halt_req in the same cycle: redirect wins; state RUN.
4. **Halt/resume:** assert halt_req at pc=0x10 with an entry pending at 0x0C.
   - 0x0C still handshakes; halted=1; no further capture.
   - Deassert halt_req: fetch resumes with out_pc=0x10.
   - Redirect to 0x40 while halted: out_pc=0x40, out_inst=0x0800000D.
5. **Faults:**
   - Redirect to 0x1A (misaligned): fault=1, fault_pc=0x1A, out_valid=0.
   - Separately, sequential fetch reaching pc=0x400: fault_pc=0x400 (0x3FC delivers normally).
   - Inputs are ignored while faulted; rst clears fault and restarts at RESET_PC.
6. **Reset mid-operation:** assert rst while out_valid=1 && out_ready=0.
   - Next cycle: all outputs equal their reset values; sequence 1 repeats.
